lc4_rob_commit: RTL and testbench
=================================

Name: lc4_rob_commit

Overview:
- 4-entry reorder buffer that receives completions from the writeback stage (W_valid, W_rob_index, W_pc_redirect, W_rddata, W_nzp, W_regfile_we, W_nzp_we) and retires instructions in program order.
- Dispatch allocates entries at the tail; the writeback stage marks them done by index; the head commits to architectural state and the free list.
- If the head's resolved next-PC differs from its predicted next-PC at commit, all younger entries are squashed and a redirect is issued.

Parameters:
IDX_W, 2, ROB index width; depth = 2**IDX_W = 4 (must match W_rob_index width)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
D_alloc  in  1  dispatch requests one entry this cycle
D_ard  in  3  architectural destination register
D_prd  in  4  physical destination register
D_old_prd  in  4  previous physical mapping of D_ard, freed at commit
D_pc  in  16  instruction PC
D_pred_pc  in  16  predicted next PC
D_ready  out  1  entry available (count < 4)
D_rob_index  out  IDX_W  index allocated if D_alloc & D_ready (= tail)
W_valid  in  1  completion strobe
W_rob_index  in  IDX_W  entry completing
W_pc_redirect  in  16  resolved next PC
W_rddata  in  16  result value
W_nzp  in  3  result NZP
W_regfile_we  in  1  writes register
W_nzp_we  in  1  writes NZP
C_valid  out  1  head commits this cycle
C_rob_index  out  IDX_W  head index
C_ard  out  3  committed arch dest
C_prd  out  4  committed physical dest
C_old_prd  out  4  physical reg returned to free list (valid when C_valid & C_regfile_we)
C_regfile_we  out  1  committed register write (gated by C_valid)
C_nzp_we  out  1  committed NZP write (gated by C_valid)
C_nzp  out  3  committed NZP
C_rddata  out  16  committed value
C_pc  out  16  committed PC
C_flush  out  1  squash younger entries / redirect fetch
C_flush_pc  out  16  redirect target (= resolved next PC of head)

Behaviour:
- State:
  - Per entry: valid, done, ard, prd, old_prd, pc, pred_pc, actual_pc, rddata, nzp, regfile_we, nzp_we.
  - head, tail: IDX_W bits, wrap modulo 4.
  - count: 3 bits, 0..4.
- Reset (rst=0, async): head=tail=count=0; all valid/done=0.
  - Outputs during reset: D_ready=1, D_rob_index=0, C_valid=0, C_flush=0, C_flush_pc=0, all C_* we=0.
  - Data fields need not be cleared.
- Allocation:
  - D_ready = (count != 4), from registered count only.
  - When D_alloc & D_ready & ~C_flush, the next edge writes entry[tail] with valid=1, done=0 and the D_* fields, then tail+1.
  - D_alloc while full is dropped. No same-cycle bypass from a commit freeing a slot.
- Writeback:
  - When W_valid & entry[W_rob_index].valid & ~C_flush, the next edge sets done=1 and captures W_pc_redirect, W_rddata, W_nzp, W_regfile_we, W_nzp_we.
  - Writeback to an invalid entry is ignored. A second writeback to a done entry overwrites it.
- Commit (combinational from registered state):
  - C_valid = entry[head].valid & entry[head].done.
  - Minimum latency W_valid -> C_valid is 1 cycle (no bypass).
  - On C_valid: the entry is cleared and head+1 at the next edge; one commit per cycle maximum.
- Misprediction:
  - C_flush = C_valid & (actual_pc != pred_pc); C_flush_pc = actual_pc.
  - The head instruction itself still commits (C_* we asserted).
  - At the next edge: all entries invalid, head = tail = head+1, count=0.
  - Same-cycle D_alloc and W_valid are dropped.
- Count update: count + (alloc accepted) - (C_valid), except on flush (count=0). Simultaneous alloc and commit leaves count unchanged.
- Reset mid-operation: immediate clear; in-flight entries are lost; no commit or flush is asserted.
- Out-of-order completion: younger done entries wait until all older entries commit.

Test Plan:
- Reset then idle -> D_ready=1, D_rob_index=0, C_valid=0, C_flush=0.
- Allocate 4 (PCs 0x0010..0x0013, pred=pc+1) -> indices 0,1,2,3; D_ready=0 after the 4th; 5th D_alloc dropped, tail stays 0.
- Writeback idx 2, then 1, then 0, each with W_pc_redirect=pc+1 -> no commit until idx0 done.
  - Then C_valid on 3 consecutive cycles with C_pc 0x0010, 0x0011, 0x0012; count=1 after.
- Entry pc 0x0020, pred 0x0021, W_pc_redirect=0x0040, W_regfile_we=1, prd=5, old_prd=2.
  - Required: C_valid=1, C_flush=1, C_flush_pc=0x0040, C_old_prd=2.
  - Next cycle: count=0, D_ready=1, younger entries never commit.
- Full ROB with head done and D_alloc in the same cycle -> commit occurs, alloc dropped, count 4->3.
- Writeback to an unallocated index (W_rob_index=3, empty ROB) -> no state change.
- Reset asserted while count=2 -> C_valid=0 immediately, count=0.

Source files
------------

// File: rtl/lc4_rob_commit.sv
// lc4_rob_commit: 4-entry reorder buffer. Dispatch allocates at the tail,
// writeback marks entries done by index, and the head retires in program
// order. A head whose resolved next-PC disagrees with its prediction still
// commits, but squashes every younger entry and redirects fetch.
module lc4_rob_commit #(
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             D_alloc,
  input  logic [2:0]       D_ard,
  input  logic [3:0]       D_prd,
  input  logic [3:0]       D_old_prd,
  input  logic [15:0]      D_pc,
  input  logic [15:0]      D_pred_pc,
  output logic             D_ready,
  output logic [IDX_W-1:0] D_rob_index,

  input  logic             W_valid,
  input  logic [IDX_W-1:0] W_rob_index,
  input  logic [15:0]      W_pc_redirect,
  input  logic [15:0]      W_rddata,
  input  logic [2:0]       W_nzp,
  input  logic             W_regfile_we,
  input  logic             W_nzp_we,

  output logic             C_valid,
  output logic [IDX_W-1:0] C_rob_index,
  output logic [2:0]       C_ard,
  output logic [3:0]       C_prd,
  output logic [3:0]       C_old_prd,
  output logic             C_regfile_we,
  output logic             C_nzp_we,
  output logic [2:0]       C_nzp,
  output logic [15:0]      C_rddata,
  output logic [15:0]      C_pc,
  output logic             C_flush,
  output logic [15:0]      C_flush_pc
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  // Control bits live in vectors so they can be reset; payload fields do not
  // need a reset because valid/done gate every use of them.
  logic [DEPTH-1:0] valid_reg, valid_next;
  logic [DEPTH-1:0] done_reg, done_next;

  logic [2:0]  ard_reg        [DEPTH];
  logic [3:0]  prd_reg        [DEPTH];
  logic [3:0]  old_prd_reg    [DEPTH];
  logic [15:0] pc_reg         [DEPTH];
  logic [15:0] pred_pc_reg    [DEPTH];
  logic [15:0] actual_pc_reg  [DEPTH];
  logic [15:0] rddata_reg     [DEPTH];
  logic [2:0]  nzp_reg        [DEPTH];
  logic        regfile_we_reg [DEPTH];
  logic        nzp_we_reg     [DEPTH];

  logic [IDX_W-1:0] head_reg, head_next;
  logic [IDX_W-1:0] tail_reg, tail_next;
  logic [IDX_W:0]   count_reg, count_next;

  logic             commit;
  logic             flush;
  logic             alloc_acc;
  logic             wb_acc;
  logic [DEPTH-1:0] alloc_hit;
  logic [DEPTH-1:0] wb_hit;
  logic [DEPTH-1:0] commit_hit;

  // Commit and flush decisions depend only on registered state, so a
  // writeback is never visible at the head in the same cycle.
  assign commit    = valid_reg[head_reg] & done_reg[head_reg];
  assign flush     = commit & (actual_pc_reg[head_reg] != pred_pc_reg[head_reg]);
  assign alloc_acc = D_alloc & D_ready & ~flush;
  assign wb_acc    = W_valid & valid_reg[W_rob_index] & ~flush;

  // Per-entry decode of which operation targets this slot and its next
  // valid/done bits. Alloc and writeback never hit the same slot: alloc only
  // targets a free slot, and writeback only targets an occupied one.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    localparam logic [IDX_W-1:0] ENTRY_IDX = IDX_W'(gi);

    assign alloc_hit[gi]  = alloc_acc & (tail_reg == ENTRY_IDX);
    assign wb_hit[gi]     = wb_acc & (W_rob_index == ENTRY_IDX);
    assign commit_hit[gi] = commit & (head_reg == ENTRY_IDX);

    assign valid_next[gi] = flush          ? 1'b0 :
                            commit_hit[gi] ? 1'b0 :
                            alloc_hit[gi]  ? 1'b1 : valid_reg[gi];

    assign done_next[gi]  = flush          ? 1'b0 :
                            commit_hit[gi] ? 1'b0 :
                            alloc_hit[gi]  ? 1'b0 :
                            wb_hit[gi]     ? 1'b1 : done_reg[gi];
  end

  // Pointer and occupancy update; a flush collapses the buffer to empty just
  // past the committing head.
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (commit) begin
      head_next = head_reg + IDX_ONE;
    end
    if (flush) begin
      tail_next  = head_reg + IDX_ONE;
      count_next = '0;
    end else begin
      if (alloc_acc) begin
        tail_next = tail_reg + IDX_ONE;
      end
      case ({alloc_acc, commit})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  // Control state register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= '0;
      done_reg  <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      valid_reg <= valid_next;
      done_reg  <= done_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Payload capture: dispatch fields at allocation, result fields at writeback.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_hit[i]) begin
        ard_reg[i]     <= D_ard;
        prd_reg[i]     <= D_prd;
        old_prd_reg[i] <= D_old_prd;
        pc_reg[i]      <= D_pc;
        pred_pc_reg[i] <= D_pred_pc;
      end
      if (wb_hit[i]) begin
        actual_pc_reg[i]  <= W_pc_redirect;
        rddata_reg[i]     <= W_rddata;
        nzp_reg[i]        <= W_nzp;
        regfile_we_reg[i] <= W_regfile_we;
        nzp_we_reg[i]     <= W_nzp_we;
      end
    end
  end

  // Dispatch and commit outputs; write enables and the redirect target are
  // gated by commit so nothing leaks while the buffer is idle or in reset.
  always_comb begin
    D_ready      = (count_reg != CNT_FULL);
    D_rob_index  = tail_reg;
    C_valid      = commit;
    C_rob_index  = head_reg;
    C_ard        = ard_reg[head_reg];
    C_prd        = prd_reg[head_reg];
    C_old_prd    = old_prd_reg[head_reg];
    C_regfile_we = commit & regfile_we_reg[head_reg];
    C_nzp_we     = commit & nzp_we_reg[head_reg];
    C_nzp        = nzp_reg[head_reg];
    C_rddata     = rddata_reg[head_reg];
    C_pc         = pc_reg[head_reg];
    C_flush      = flush;
    C_flush_pc   = commit ? actual_pc_reg[head_reg] : 16'h0000;
  end

endmodule

// File: tb/tb_lc4_rob_commit.sv
// Testbench for lc4_rob_commit: scenario tasks drive dispatch/writeback and
// check inline; a commit monitor pops an in-order scoreboard on each C_valid.
module tb_lc4_rob_commit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        D_alloc = 1'b0;
  logic [2:0]  D_ard = '0;
  logic [3:0]  D_prd = '0;
  logic [3:0]  D_old_prd = '0;
  logic [15:0] D_pc = '0;
  logic [15:0] D_pred_pc = '0;
  logic        D_ready;
  logic [1:0]  D_rob_index;
  logic        W_valid = 1'b0;
  logic [1:0]  W_rob_index = '0;
  logic [15:0] W_pc_redirect = '0;
  logic [15:0] W_rddata = '0;
  logic [2:0]  W_nzp = '0;
  logic        W_regfile_we = 1'b0;
  logic        W_nzp_we = 1'b0;
  logic        C_valid;
  logic [1:0]  C_rob_index;
  logic [2:0]  C_ard;
  logic [3:0]  C_prd;
  logic [3:0]  C_old_prd;
  logic        C_regfile_we;
  logic        C_nzp_we;
  logic [2:0]  C_nzp;
  logic [15:0] C_rddata;
  logic [15:0] C_pc;
  logic        C_flush;
  logic [15:0] C_flush_pc;

  int checks = 0;
  int failures = 0;

  // Expected contents per ROB slot, filled as stimulus is driven.
  logic [2:0]  m_ard [4];
  logic [3:0]  m_prd [4];
  logic [3:0]  m_old [4];
  logic [15:0] m_pc  [4];
  logic [15:0] m_pred[4];
  logic [15:0] m_act [4];
  logic [15:0] m_rd  [4];
  logic [2:0]  m_nzp [4];
  logic        m_rwe [4];
  logic        m_nwe [4];
  int          sb[$];   // slot indices in expected commit order

  int          mon_idx;
  logic [49:0] mon_got, mon_exp;

  lc4_rob_commit #(.IDX_W(2)) dut (
    .clk(clk), .rst(rst),
    .D_alloc(D_alloc), .D_ard(D_ard), .D_prd(D_prd), .D_old_prd(D_old_prd),
    .D_pc(D_pc), .D_pred_pc(D_pred_pc), .D_ready(D_ready), .D_rob_index(D_rob_index),
    .W_valid(W_valid), .W_rob_index(W_rob_index), .W_pc_redirect(W_pc_redirect),
    .W_rddata(W_rddata), .W_nzp(W_nzp), .W_regfile_we(W_regfile_we), .W_nzp_we(W_nzp_we),
    .C_valid(C_valid), .C_rob_index(C_rob_index), .C_ard(C_ard), .C_prd(C_prd),
    .C_old_prd(C_old_prd), .C_regfile_we(C_regfile_we), .C_nzp_we(C_nzp_we),
    .C_nzp(C_nzp), .C_rddata(C_rddata), .C_pc(C_pc), .C_flush(C_flush),
    .C_flush_pc(C_flush_pc)
  );

  always #5 clk = ~clk;

  // Commit monitor: every commit must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst === 1'b1 && C_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_commit idx=%0d pc=%h", C_rob_index, C_pc);
      end else begin
        mon_idx = sb.pop_front();
        mon_got = {C_rob_index, C_ard, C_prd, C_old_prd, C_pc, C_rddata, C_nzp,
                   C_regfile_we, C_nzp_we};
        mon_exp = {2'(mon_idx), m_ard[mon_idx], m_prd[mon_idx], m_old[mon_idx],
                   m_pc[mon_idx], m_rd[mon_idx], m_nzp[mon_idx],
                   m_rwe[mon_idx], m_nwe[mon_idx]};
        checks++;
        if (mon_got !== mon_exp) begin
          failures++;
          $display("FAIL commit_fields got=%h exp=%h", mon_got, mon_exp);
        end
        checks++;
        if ({C_flush, C_flush_pc} !== {(m_act[mon_idx] != m_pred[mon_idx]), m_act[mon_idx]}) begin
          failures++;
          $display("FAIL commit_flush got flush=%b pc=%h exp flush=%b pc=%h", C_flush, C_flush_pc,
                   (m_act[mon_idx] != m_pred[mon_idx]), m_act[mon_idx]);
        end
        if (m_act[mon_idx] != m_pred[mon_idx]) sb.delete();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [1:0] idx, input logic [2:0] ard, input logic [3:0] prd,
                       input logic [3:0] old, input logic [15:0] pc, input logic [15:0] pred,
                       input bit accept);
    D_alloc = 1'b1; D_ard = ard; D_prd = prd; D_old_prd = old; D_pc = pc; D_pred_pc = pred;
    if (accept) begin
      m_ard[idx] = ard; m_prd[idx] = prd; m_old[idx] = old; m_pc[idx] = pc; m_pred[idx] = pred;
      sb.push_back(int'(idx));
    end
    tick();
    D_alloc = 1'b0;
  endtask

  task automatic wb(input logic [1:0] idx, input logic [15:0] act, input logic [15:0] rd,
                    input logic [2:0] nzp, input logic rwe, input logic nwe, input bit upd);
    W_valid = 1'b1; W_rob_index = idx; W_pc_redirect = act; W_rddata = rd; W_nzp = nzp;
    W_regfile_we = rwe; W_nzp_we = nwe;
    if (upd) begin
      m_act[idx] = act; m_rd[idx] = rd; m_nzp[idx] = nzp; m_rwe[idx] = rwe; m_nwe[idx] = nwe;
    end
    tick();
    W_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && sb.size() != 0; n++) tick();
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({D_ready, D_rob_index, C_valid, C_flush, C_flush_pc, C_regfile_we, C_nzp_we} !==
        {1'b1, 2'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b idx=%0d cv=%b fl=%b fpc=%h rwe=%b nwe=%b exp 1 0 0 0 0000 0 0",
               D_ready, D_rob_index, C_valid, C_flush, C_flush_pc, C_regfile_we, C_nzp_we);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    checks++;
    if ({D_ready, D_rob_index, C_valid, C_flush} !== {1'b1, 2'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL idle_after_reset got rdy=%b idx=%0d cv=%b fl=%b exp 1 0 0 0",
               D_ready, D_rob_index, C_valid, C_flush);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({D_ready, D_rob_index} !== {1'b1, 2'(i)}) begin
        failures++;
        $display("FAIL fill_idx%0d got rdy=%b idx=%0d exp rdy=1 idx=%0d", i, D_ready, D_rob_index, i);
      end
      alloc(2'(i), 3'(i + 1), 4'(8 + i), 4'(i), 16'(16'h10 + i), 16'(16'h11 + i), 1'b1);
    end
    checks++;
    if (D_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready got %b exp 0", D_ready);
    end
    alloc(2'd0, 3'd7, 4'hF, 4'hF, 16'h0099, 16'h009A, 1'b0);
    checks++;
    if ({D_ready, D_rob_index, C_valid} !== {1'b0, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL drop_when_full got rdy=%b idx=%0d cv=%b exp 0 0 0", D_ready, D_rob_index, C_valid);
    end
  endtask

  task automatic test_out_of_order();
    wb(2'd2, 16'h0013, 16'hA002, 3'b001, 1'b1, 1'b1, 1'b1);
    checks++;
    if (C_valid !== 1'b0) begin
      failures++;
      $display("FAIL ooo_wait_2 got cv=%b exp 0", C_valid);
    end
    wb(2'd1, 16'h0012, 16'hA001, 3'b010, 1'b1, 1'b0, 1'b1);
    checks++;
    if (C_valid !== 1'b0) begin
      failures++;
      $display("FAIL ooo_wait_1 got cv=%b exp 0", C_valid);
    end
    wb(2'd0, 16'h0011, 16'hA000, 3'b100, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({C_valid, C_pc, C_flush} !== {1'b1, 16'(16'h10 + k), 1'b0}) begin
        failures++;
        $display("FAIL ooo_commit%0d got cv=%b pc=%h fl=%b exp 1 %h 0", k, C_valid, C_pc, C_flush,
                 16'(16'h10 + k));
      end
      tick();
    end
    checks++;
    if ({C_valid, D_ready, D_rob_index} !== {1'b0, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL ooo_after got cv=%b rdy=%b idx=%0d exp 0 1 0", C_valid, D_ready, D_rob_index);
    end
  endtask

  task automatic test_full_commit();
    // One entry (slot 3) remains, so three more allocations fill the buffer.
    for (int i = 0; i < 3; i++) alloc(2'(i), 3'(i), 4'(i), 4'(12 + i), 16'(16'h30 + i), 16'(16'h31 + i), 1'b1);
    checks++;
    if (D_ready !== 1'b0) begin
      failures++;
      $display("FAIL refill_ready got %b exp 0", D_ready);
    end
    wb(2'd3, 16'h0014, 16'hB003, 3'b010, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({C_valid, D_ready} !== {1'b1, 1'b0}) begin
      failures++;
      $display("FAIL full_head_done got cv=%b rdy=%b exp 1 0", C_valid, D_ready);
    end
    alloc(2'd3, 3'd6, 4'hE, 4'hE, 16'h0088, 16'h0089, 1'b0);
    checks++;
    if ({D_ready, D_rob_index, C_valid} !== {1'b1, 2'd3, 1'b0}) begin
      failures++;
      $display("FAIL full_commit_drop got rdy=%b idx=%0d cv=%b exp 1 3 0", D_ready, D_rob_index, C_valid);
    end
    wb(2'd0, 16'h0031, 16'hB000, 3'b001, 1'b1, 1'b1, 1'b1);
    wb(2'd1, 16'h0032, 16'hB001, 3'b100, 1'b0, 1'b0, 1'b1);
    wb(2'd2, 16'h0033, 16'hB002, 3'b010, 1'b1, 1'b1, 1'b1);
    drain();
    checks++;
    if ({sb.size() == 0, C_valid, D_ready, D_rob_index} !== {1'b1, 1'b0, 1'b1, 2'd3}) begin
      failures++;
      $display("FAIL full_drain got left=%0d cv=%b rdy=%b idx=%0d exp 0 0 1 3", sb.size(), C_valid,
               D_ready, D_rob_index);
    end
  endtask

  task automatic test_mispredict();
    alloc(2'd3, 3'd1, 4'd5, 4'd2, 16'h0020, 16'h0021, 1'b1);
    alloc(2'd0, 3'd2, 4'd6, 4'd3, 16'h0021, 16'h0022, 1'b1);
    alloc(2'd1, 3'd3, 4'd7, 4'd4, 16'h0022, 16'h0023, 1'b1);
    wb(2'd0, 16'h0022, 16'hC000, 3'b001, 1'b1, 1'b0, 1'b1);
    wb(2'd1, 16'h0023, 16'hC001, 3'b001, 1'b1, 1'b0, 1'b1);
    wb(2'd3, 16'h0040, 16'h5555, 3'b001, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({C_valid, C_flush, C_flush_pc, C_old_prd, C_regfile_we} !== {1'b1, 1'b1, 16'h0040, 4'd2, 1'b1}) begin
      failures++;
      $display("FAIL mispredict got cv=%b fl=%b fpc=%h old=%0d rwe=%b exp 1 1 0040 2 1",
               C_valid, C_flush, C_flush_pc, C_old_prd, C_regfile_we);
    end
    // Same-cycle dispatch and writeback must both be squashed.
    D_alloc = 1'b1; D_pc = 16'h0077; D_pred_pc = 16'h0078;
    W_valid = 1'b1; W_rob_index = 2'd0; W_pc_redirect = 16'h0099;
    tick();
    D_alloc = 1'b0; W_valid = 1'b0;
    checks++;
    if ({D_ready, D_rob_index, C_valid, C_flush} !== {1'b1, 2'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL after_flush got rdy=%b idx=%0d cv=%b fl=%b exp 1 0 0 0", D_ready, D_rob_index,
               C_valid, C_flush);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (C_valid !== 1'b0) begin
        failures++;
        $display("FAIL squashed_commit%0d got cv=%b pc=%h exp 0", k, C_valid, C_pc);
      end
    end
  endtask

  task automatic test_wb_invalid();
    wb(2'd3, 16'h1234, 16'hDEAD, 3'b100, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({C_valid, C_flush, D_ready, D_rob_index} !== {1'b0, 1'b0, 1'b1, 2'd0}) begin
        failures++;
        $display("FAIL wb_invalid%0d got cv=%b fl=%b rdy=%b idx=%0d exp 0 0 1 0", k, C_valid, C_flush,
                 D_ready, D_rob_index);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    alloc(2'd0, 3'd4, 4'd9, 4'd1, 16'h0050, 16'h0051, 1'b1);
    alloc(2'd1, 3'd5, 4'd10, 4'd2, 16'h0051, 16'h0052, 1'b1);
    wb(2'd0, 16'h0051, 16'hE000, 3'b010, 1'b1, 1'b1, 1'b1);
    checks++;
    if (C_valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_commit got cv=%b exp 1", C_valid);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({C_valid, C_flush, C_regfile_we, D_ready, D_rob_index} !== {1'b0, 1'b0, 1'b0, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL mid_reset got cv=%b fl=%b rwe=%b rdy=%b idx=%0d exp 0 0 0 1 0", C_valid, C_flush,
               C_regfile_we, D_ready, D_rob_index);
    end
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    // Count must restart from zero: exactly four allocations fit again.
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({D_ready, D_rob_index} !== {1'b1, 2'(i)}) begin
        failures++;
        $display("FAIL post_reset_idx%0d got rdy=%b idx=%0d exp 1 %0d", i, D_ready, D_rob_index, i);
      end
      alloc(2'(i), 3'(i), 4'(i), 4'(i), 16'(16'h60 + i), 16'(16'h61 + i), 1'b1);
    end
    checks++;
    if (D_ready !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_full got %b exp 0", D_ready);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_out_of_order();
    test_full_commit();
    test_mispredict();
    test_wb_invalid();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1);
  end

endmodule
